// File: rtl/mem_data_ctrl_pkg.sv
// mem_data_ctrl_pkg: shared types, constants and helpers for the data-side memory controller.
package mem_data_ctrl_pkg;
  localparam int ROB_W = 4;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [ROB_W-1:0] rob_idx_t;
  localparam word_t ZERO_WORD = '0;
  localparam logic [3:0] LEN_BYTE = 4'd0;
  localparam logic [3:0] LEN_HALF = 4'd1;
  localparam logic [1:0] IO_HI = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, STORE, IO_WAIT, DONE} state_e;
  // Unknown length codes fall through to a full word.
  function automatic logic [2:0] byte_cnt(input logic [3:0] len);
    return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_data_ctrl_ld_extend.sv
// mem_ld_extend: turns top-aligned raw load bytes into a zero/sign-extended word.
module mem_ld_extend
  import mem_data_ctrl_pkg::*;
(
  input  logic [2:0] n_i,
  input  logic       sext_i,
  input  word_t      raw_i,
  output word_t      word_o
);
  logic s;
  assign s = sext_i & raw_i[31];
  assign word_o = n_i == 3'd1 ? {{24{s}}, raw_i[31:24]} :
                  n_i == 3'd2 ? {{16{s}}, raw_i[31:16]} : raw_i;
endmodule

// File: rtl/mem_data_ctrl.sv
// mem_data_ctrl: serialises SLB loads and ROB stores onto the byte-wide RAM port.
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_HI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rb,
  input  logic       mc_ld_ena,
  input  addr_t      mc_ld_addr,
  input  logic [3:0] mc_ld_len,
  input  logic       mc_ld_sext,
  input  rob_idx_t   mc_ld_src,
  output logic       mc_ld_done,
  output word_t      mc_ld_data,
  output logic       cdb_ld_valid,
  output rob_idx_t   cdb_ld_src,
  output word_t      cdb_ld_val,
  input  logic       st_ena,
  input  addr_t      st_addr,
  input  word_t      st_val,
  input  logic [3:0] st_len,
  output logic       st_done,
  input  logic       io_buffer_full,
  input  logic [7:0] mem_din,
  output logic [7:0] mem_dout,
  output addr_t      mem_a,
  output logic       mem_wr
);
  state_e     state_q;
  logic [2:0] cnt_q, n_q, j;
  logic       sext_q, wr_q, ld_done_q, st_done_q;
  rob_idx_t   src_q;
  word_t      data_q, mem_a_q, ld_data_q, shifted, ext;
  logic [7:0] dout_q;
  assign j = cnt_q + 3'd1;
  // RAM byte arriving now joins the shift register; after n loads it is top-aligned.
  assign shifted = {mem_din, data_q[31:8]};
  mem_ld_extend u_ext (.n_i(n_q), .sext_i(sext_q), .raw_i(shifted), .word_o(ext));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      sext_q    <= 1'b0;
      src_q     <= '0;
      data_q    <= ZERO_WORD;
      mem_a_q   <= ZERO_WORD;
      ld_data_q <= ZERO_WORD;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (st_ena) begin
            n_q     <= byte_cnt(st_len);
            mem_a_q <= st_addr;
            if (st_addr[17:16] == IO_ADDR_HI && io_buffer_full) begin
              state_q <= IO_WAIT;
              data_q  <= st_val;
            end else begin
              state_q <= STORE;
              wr_q    <= 1'b1;
              dout_q  <= st_val[7:0];
              data_q  <= {8'h00, st_val[31:8]};
            end
          end else if (mc_ld_ena && !rb) begin
            state_q <= LOAD;
            n_q     <= byte_cnt(mc_ld_len);
            sext_q  <= mc_ld_sext;
            src_q   <= mc_ld_src;
            mem_a_q <= mc_ld_addr;
          end
        end
        IO_WAIT: if (!io_buffer_full) begin
          state_q <= STORE;
          wr_q    <= 1'b1;
          dout_q  <= data_q[7:0];
          data_q  <= {8'h00, data_q[31:8]};
        end
        STORE: begin
          cnt_q <= j;
          if (j < n_q) begin
            mem_a_q <= mem_a_q + 32'd1;
            dout_q  <= data_q[7:0];
            data_q  <= {8'h00, data_q[31:8]};
          end else begin
            wr_q      <= 1'b0;
            st_done_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        LOAD: if (rb) state_q <= IDLE;
        else begin
          cnt_q  <= j;
          data_q <= shifted;
          if (j < n_q) mem_a_q <= mem_a_q + 32'd1;
          if (j > n_q) begin
            ld_data_q <= ext;
            ld_done_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          ld_done_q <= 1'b0;
          st_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_wr       = wr_q & rdy;
  assign mem_a        = mem_a_q;
  assign mem_dout     = dout_q;
  assign mc_ld_done   = ld_done_q & rdy & ~rb;
  assign cdb_ld_valid = ld_done_q & rdy & ~rb;
  assign mc_ld_data   = ld_data_q;
  assign cdb_ld_val   = ld_data_q;
  assign cdb_ld_src   = src_q;
  assign st_done      = st_done_q & rdy;
endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb_mem_data_ctrl: randomized and directed checks of mem_data_ctrl against a byte-memory model.
module tb_mem_data_ctrl;
  import mem_data_ctrl_pkg::*;
  logic clk = 0, rst = 1, rdy = 1, rb = 0;
  logic mc_ld_ena = 0, mc_ld_sext = 0, st_ena = 0, io_buffer_full = 0;
  word_t mc_ld_addr = '0, st_addr = '0, st_val = '0;
  logic [3:0] mc_ld_len = '0, st_len = '0;
  rob_idx_t mc_ld_src = '0;
  logic mc_ld_done, cdb_ld_valid, st_done, mem_wr;
  word_t mc_ld_data, cdb_ld_val, mem_a;
  rob_idx_t cdb_ld_src;
  logic [7:0] mem_din = '0, mem_dout;
  int errors = 0, checks = 0;
  logic [7:0] ram [word_t];
  logic [7:0] exp_m [word_t];

  mem_data_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .mc_ld_ena(mc_ld_ena), .mc_ld_addr(mc_ld_addr), .mc_ld_len(mc_ld_len),
    .mc_ld_sext(mc_ld_sext), .mc_ld_src(mc_ld_src), .mc_ld_done(mc_ld_done),
    .mc_ld_data(mc_ld_data), .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src),
    .cdb_ld_val(cdb_ld_val), .st_ena(st_ena), .st_addr(st_addr), .st_val(st_val),
    .st_len(st_len), .st_done(st_done), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_b(input word_t a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input word_t a);
    return ram.exists(a) ? ram[a] : init_b(a);
  endfunction
  function automatic logic [7:0] exp_rd(input word_t a);
    return exp_m.exists(a) ? exp_m[a] : init_b(a);
  endfunction
  function automatic int nbytes(input logic [3:0] len);
    return len == 0 ? 1 : len == 1 ? 2 : 4;
  endfunction

  // Byte RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic preload(input word_t a, input logic [7:0] b);
    ram[a] = b;
    exp_m[a] = b;
  endtask

  task automatic do_load(input word_t a, input logic [3:0] len, input logic sx,
                         input rob_idx_t tag, output word_t got);
    int n = nbytes(len);
    int dm = 0;
    word_t raw = '0, expv;
    logic [63:0] mask;
    for (int i = 0; i < n; i++) raw[8*i +: 8] = exp_rd(a + 32'(i));
    mask = (64'd1 << (8 * n)) - 64'd1;
    expv = raw | ((sx && raw[8*n-1]) ? ~mask[31:0] : 32'h0);
    @(negedge clk);
    mc_ld_ena = 1; mc_ld_addr = a; mc_ld_len = len; mc_ld_sext = sx; mc_ld_src = tag;
    for (int m = 1; m <= 30 && dm == 0; m++) begin
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b0) begin errors++; $display("FAIL ld_wr: mem_wr=%b want 0", mem_wr); end
      if (m <= n) begin
        checks++;
        if (mem_a !== a + 32'(m - 1)) begin
          errors++; $display("FAIL ld_addr: mem_a=%h want %h", mem_a, a + 32'(m - 1));
        end
      end
      if (mc_ld_done === 1'b1) dm = m;
    end
    got = mc_ld_data;
    checks += 5;
    if (dm != n + 2) begin errors++; $display("FAIL ld_latency: cycles=%0d want %0d", dm - 1, n + 1); end
    if (mc_ld_data !== expv) begin errors++; $display("FAIL ld_data: got %h want %h", mc_ld_data, expv); end
    if (cdb_ld_valid !== 1'b1) begin errors++; $display("FAIL cdb_valid: got %b want 1", cdb_ld_valid); end
    if (cdb_ld_src !== tag) begin errors++; $display("FAIL cdb_src: got %h want %h", cdb_ld_src, tag); end
    if (cdb_ld_val !== expv) begin errors++; $display("FAIL cdb_val: got %h want %h", cdb_ld_val, expv); end
    mc_ld_ena = 0;
    @(negedge clk);
    checks++;
    if (mc_ld_done !== 1'b0) begin errors++; $display("FAIL ld_pulse: done=%b want 0", mc_ld_done); end
  endtask

  task automatic do_store(input word_t a, input word_t v, input logic [3:0] len,
                          input int f, input int rb_m);
    int n = nbytes(len);
    int w = (a[17:16] == 2'b11) ? f : 0;
    int dm = 0;
    logic ew;
    for (int i = 0; i < n; i++) exp_m[a + 32'(i)] = v[8*i +: 8];
    @(negedge clk);
    st_ena = 1; st_addr = a; st_val = v; st_len = len; io_buffer_full = (f > 0);
    for (int m = 1; m <= 30 && dm == 0; m++) begin
      @(negedge clk);
      ew = (m > w) && (m <= w + n);
      checks++;
      if (mem_wr !== ew) begin errors++; $display("FAIL st_wr: cycle %0d mem_wr=%b want %b", m, mem_wr, ew); end
      if (ew) begin
        checks += 2;
        if (mem_a !== a + 32'(m - w - 1)) begin
          errors++; $display("FAIL st_addr: mem_a=%h want %h", mem_a, a + 32'(m - w - 1));
        end
        if (mem_dout !== v[8*(m-w-1) +: 8]) begin
          errors++; $display("FAIL st_dout: got %h want %h", mem_dout, v[8*(m-w-1) +: 8]);
        end
      end
      if (st_done === 1'b1) dm = m;
      if (m == f) io_buffer_full = 0;
      rb = (m == rb_m);
    end
    rb = 0; io_buffer_full = 0; st_ena = 0;
    checks++;
    if (dm != w + n + 1) begin errors++; $display("FAIL st_done: cycle=%0d want %0d", dm, w + n + 1); end
    @(negedge clk);
    checks++;
    if (st_done !== 1'b0) begin errors++; $display("FAIL st_pulse: done=%b want 0", st_done); end
  endtask

  task automatic test_reset;
    st_ena = 1; st_addr = 32'h123; st_val = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks += 9;
    if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", mem_wr); end
    if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_a: got %h want 0", mem_a); end
    if (mem_dout !== 8'h0) begin errors++; $display("FAIL rst_dout: got %h want 0", mem_dout); end
    if (mc_ld_done !== 1'b0) begin errors++; $display("FAIL rst_lddone: got %b want 0", mc_ld_done); end
    if (mc_ld_data !== 32'h0) begin errors++; $display("FAIL rst_lddata: got %h want 0", mc_ld_data); end
    if (cdb_ld_valid !== 1'b0) begin errors++; $display("FAIL rst_cdbv: got %b want 0", cdb_ld_valid); end
    if (cdb_ld_src !== '0) begin errors++; $display("FAIL rst_cdbsrc: got %h want 0", cdb_ld_src); end
    if (cdb_ld_val !== 32'h0) begin errors++; $display("FAIL rst_cdbval: got %h want 0", cdb_ld_val); end
    if (st_done !== 1'b0) begin errors++; $display("FAIL rst_stdone: got %b want 0", st_done); end
    st_ena = 0;
    rst = 0;
  endtask

  task automatic test_loads;
    word_t got;
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h300, 8'h80); preload(32'h310, 8'h01); preload(32'h311, 8'h80);
    do_load(32'h100, 4'd3, 1'b0, 4'd5, got);
    checks++;
    if (got !== 32'h4433_2211) begin errors++; $display("FAIL lw_const: got %h want 44332211", got); end
    do_load(32'h300, 4'd0, 1'b1, 4'd6, got);
    checks++;
    if (got !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", got); end
    do_load(32'h300, 4'd0, 1'b0, 4'd7, got);
    checks++;
    if (got !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", got); end
    do_load(32'h310, 4'd1, 1'b1, 4'd8, got);
    checks++;
    if (got !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext: got %h want ffff8001", got); end
    do_load(32'hFFFF_FFFE, 4'd3, 1'b0, 4'd9, got);
  endtask

  task automatic test_store;
    word_t got;
    do_store(32'h200, 32'hDEAD_BEEF, 4'd3, 0, 0);
    do_load(32'h200, 4'd3, 1'b0, 4'd1, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback: got %h want deadbeef", got); end
    do_store(32'h210, 32'h1234_5678, 4'd1, 0, 0);
    do_store(32'h220, 32'hAABB_CCDD, 4'd2, 0, 0);
    do_load(32'h210, 4'd3, 1'b0, 4'd2, got);
    do_load(32'h220, 4'd3, 1'b0, 4'd3, got);
  endtask

  task automatic test_back_to_back;
    word_t v = $urandom;
    int ms = 0, ml = 0;
    for (int i = 0; i < 4; i++) exp_m[32'h400 + 32'(i)] = v[8*i +: 8];
    @(negedge clk);
    st_ena = 1; st_addr = 32'h400; st_val = v; st_len = 4'd3;
    mc_ld_ena = 1; mc_ld_addr = 32'h400; mc_ld_len = 4'd3; mc_ld_sext = 0; mc_ld_src = 4'hC;
    for (int m = 1; m <= 40 && ml == 0; m++) begin
      @(negedge clk);
      checks++;
      if (mem_wr !== (m <= 4)) begin errors++; $display("FAIL arb_wr: cycle %0d mem_wr=%b", m, mem_wr); end
      if (st_done === 1'b1) begin ms = m; st_ena = 0; end
      if (mc_ld_done === 1'b1) ml = m;
    end
    checks += 3;
    if (ms != 5) begin errors++; $display("FAIL arb_st: st_done cycle=%0d want 5", ms); end
    if (ml != 12) begin errors++; $display("FAIL arb_ld: ld_done cycle=%0d want 12", ml); end
    if (mc_ld_data !== v) begin errors++; $display("FAIL arb_data: got %h want %h", mc_ld_data, v); end
    mc_ld_ena = 0;
    @(negedge clk);
  endtask

  task automatic test_rollback;
    word_t got;
    int seen = 0;
    @(negedge clk);
    mc_ld_ena = 1; mc_ld_addr = 32'h100; mc_ld_len = 4'd3; mc_ld_sext = 0; mc_ld_src = 4'h3;
    repeat (3) @(negedge clk);
    rb = 1; mc_ld_ena = 0;
    for (int m = 4; m <= 9; m++) begin
      @(negedge clk);
      rb = 0;
      checks++;
      if (mc_ld_done !== 1'b0 || cdb_ld_valid !== 1'b0) begin
        errors++; $display("FAIL rb_ld: cycle %0d done=%b want 0", m, mc_ld_done);
      end
    end
    do_load(32'h101, 4'd1, 1'b0, 4'h4, got);
    @(negedge clk);
    mc_ld_ena = 1; mc_ld_addr = 32'h300; mc_ld_len = 4'd0; mc_ld_src = 4'h2;
    for (int m = 1; m <= 20 && seen == 0; m++) begin
      @(negedge clk);
      if (mc_ld_done === 1'b1) seen = m;
    end
    rb = 1;
    #1;
    checks += 2;
    if (seen != 3) begin errors++; $display("FAIL rb_done_setup: cycle=%0d want 3", seen); end
    if (mc_ld_done !== 1'b0 || cdb_ld_valid !== 1'b0) begin
      errors++; $display("FAIL rb_in_done: done=%b valid=%b want 0", mc_ld_done, cdb_ld_valid);
    end
    @(negedge clk);
    rb = 0; mc_ld_ena = 0;
    do_store(32'h700, 32'hCAFE_F00D, 4'd3, 0, 2);
    do_load(32'h700, 4'd3, 1'b0, 4'h5, got);
    checks++;
    if (got !== 32'hCAFE_F00D) begin errors++; $display("FAIL rb_st: got %h want cafef00d", got); end
  endtask

  task automatic test_io;
    word_t got;
    do_store(32'h0003_0000, 32'h0000_0041, 4'd0, 3, 0);
    do_store(32'h0003_0010, 32'h1122_3344, 4'd3, 2, 0);
    do_store(32'h0002_0000, 32'h0000_0099, 4'd0, 3, 0);
    do_load(32'h0003_0000, 4'd0, 1'b0, 4'h6, got);
    do_load(32'h0003_0010, 4'd3, 1'b0, 4'h7, got);
  endtask

  task automatic test_rdy_freeze;
    word_t v = 32'h0BAD_F00D, got;
    logic ew;
    int dm = 0;
    for (int i = 0; i < 4; i++) exp_m[32'h500 + 32'(i)] = v[8*i +: 8];
    @(negedge clk);
    st_ena = 1; st_addr = 32'h500; st_val = v; st_len = 4'd3;
    for (int m = 1; m <= 20 && dm == 0; m++) begin
      @(negedge clk);
      ew = (m <= 2) || (m == 6) || (m == 7);
      checks++;
      if (mem_wr !== ew) begin errors++; $display("FAIL rdy_wr: cycle %0d mem_wr=%b want %b", m, mem_wr, ew); end
      if (ew) begin
        checks++;
        if (mem_a !== 32'h500 + 32'(m <= 2 ? m - 1 : m - 4)) begin
          errors++; $display("FAIL rdy_addr: cycle %0d mem_a=%h", m, mem_a);
        end
      end
      if (st_done === 1'b1) dm = m;
      if (m == 2) rdy = 0;
      if (m == 5) rdy = 1;
    end
    rdy = 1; st_ena = 0;
    checks++;
    if (dm != 8) begin errors++; $display("FAIL rdy_done: cycle=%0d want 8", dm); end
    do_load(32'h500, 4'd3, 1'b0, 4'hA, got);
  endtask

  task automatic test_random;
    word_t got;
    for (int i = 0; i < 30; i++) begin
      word_t a = 32'h600 + 32'($urandom_range(0, 12));
      logic [3:0] len = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_store(a, $urandom, len, 0, 0);
      else do_load(a, len, 1'($urandom_range(0, 1)), rob_idx_t'($urandom_range(0, 15)), got);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_store;
    test_back_to_back;
    test_rollback;
    test_io;
    test_rdy_freeze;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
